// File: rtl/histogram_stat.sv
// Per-frame pixel histogram into an external BRAM: clear, accumulate one pixel
// per cycle via read-modify-write, then hand the BRAM to the consumer until released.
module histogram_stat #(
  parameter int MD_SIM_ABLE   = 0,
  parameter int NB_BRAM_LATCH = 2,
  parameter int WD_IMG_DATA   = 8,
  parameter int WD_BRAM_ADR   = 8,
  parameter int WD_BRAM_DAT   = 32,
  parameter int WD_ERR_INFO   = 4
) (
  input  logic                   i_sys_clk,
  input  logic                   i_sys_resetn,
  input  logic                   s_axis_pix_tvalid,
  output logic                   s_axis_pix_tready,
  input  logic                   s_axis_pix_tuser,
  input  logic                   s_axis_pix_tlast,
  input  logic [WD_IMG_DATA-1:0] s_axis_pix_tdata,
  output logic                   m_bram_hist_ena,
  output logic                   m_bram_hist_wea,
  output logic [WD_BRAM_ADR-1:0] m_bram_hist_addra,
  output logic [WD_BRAM_DAT-1:0] m_bram_hist_dina,
  output logic                   m_bram_hist_enb,
  output logic [WD_BRAM_ADR-1:0] m_bram_hist_addrb,
  input  logic [WD_BRAM_DAT-1:0] m_bram_hist_doutb,
  output logic                   o_bram_hist_idle,
  input  logic                   i_bram_hist_release,
  output logic [31:0]            o_pix_count,
  output logic [WD_ERR_INFO-1:0] m_err_histogram_info0
);

  localparam int unsigned LAT = NB_BRAM_LATCH;
  localparam logic [WD_BRAM_ADR-1:0] CLR_LAST =
    (MD_SIM_ABLE != 0) ? WD_BRAM_ADR'(15) : {WD_BRAM_ADR{1'b1}};
  localparam logic [2:0] FLUSH_LAST = 3'(LAT - 1);

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_WAIT_SOF,
    ST_ACC,
    ST_FLUSH,
    ST_DONE
  } state_t;

  state_t state, state_nxt;

  logic [WD_BRAM_ADR-1:0] clr_adr;
  logic [2:0]             flush_cnt;
  logic [31:0]            pix_cnt;
  logic [3:0]             err;

  logic                   pix_acc;
  logic [WD_BRAM_ADR-1:0] pix_adr;

  logic                   pipe_vld [LAT];
  logic [WD_BRAM_ADR-1:0] pipe_adr [LAT];
  logic                   hist_vld [LAT];
  logic [WD_BRAM_ADR-1:0] hist_adr [LAT];
  logic [WD_BRAM_DAT-1:0] hist_dat [LAT];

  logic                   wr_vld;
  logic [WD_BRAM_ADR-1:0] wr_adr;
  logic [WD_BRAM_DAT-1:0] fwd_dat;
  logic [WD_BRAM_DAT-1:0] wr_dat;
  logic                   wr_sat;

  assign pix_adr = WD_BRAM_ADR'(s_axis_pix_tdata);
  assign wr_vld  = pipe_vld[LAT-1];
  assign wr_adr  = pipe_adr[LAT-1];

  always_ff @(posedge i_sys_clk) begin
    if (!i_sys_resetn) begin
      state     <= ST_CLEAR;
      clr_adr   <= '0;
      flush_cnt <= '0;
    end else begin
      state     <= state_nxt;
      clr_adr   <= (state == ST_CLEAR) ? clr_adr + 1'b1 : '0;
      flush_cnt <= (state == ST_FLUSH) ? flush_cnt + 3'd1 : '0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_CLEAR:    if (clr_adr == CLR_LAST) state_nxt = ST_WAIT_SOF;
      ST_WAIT_SOF: if (pix_acc) state_nxt = s_axis_pix_tlast ? ST_FLUSH : ST_ACC;
      ST_ACC:      if (pix_acc && s_axis_pix_tlast) state_nxt = ST_FLUSH;
      ST_FLUSH:    if (flush_cnt == FLUSH_LAST) state_nxt = ST_DONE;
      ST_DONE:     if (i_bram_hist_release) state_nxt = ST_CLEAR;
      default:     state_nxt = ST_CLEAR;
    endcase
  end

  // A bin read issued L cycles ago misses the writes of the last L cycles;
  // the newest matching write in that window replaces the BRAM data.
  always_comb begin
    fwd_dat = m_bram_hist_doutb;
    for (int unsigned k = 0; k < LAT; k++) begin
      if (hist_vld[LAT-1-k] && hist_adr[LAT-1-k] == wr_adr) fwd_dat = hist_dat[LAT-1-k];
    end
    wr_sat = (fwd_dat == {WD_BRAM_DAT{1'b1}});
    wr_dat = wr_sat ? fwd_dat : fwd_dat + 1'b1;
  end

  always_comb begin
    s_axis_pix_tready     = 1'b0;
    pix_acc               = 1'b0;
    m_bram_hist_enb       = 1'b0;
    m_bram_hist_addrb     = '0;
    m_bram_hist_ena       = 1'b0;
    m_bram_hist_wea       = 1'b0;
    m_bram_hist_addra     = '0;
    m_bram_hist_dina      = '0;
    o_bram_hist_idle      = 1'b0;
    if (i_sys_resetn) begin
      s_axis_pix_tready = (state == ST_WAIT_SOF) || (state == ST_ACC);
      pix_acc = s_axis_pix_tvalid && s_axis_pix_tready &&
                ((state == ST_ACC) || s_axis_pix_tuser);
      m_bram_hist_enb   = pix_acc;
      m_bram_hist_addrb = pix_acc ? pix_adr : '0;
      o_bram_hist_idle  = (state == ST_DONE);
      if (state == ST_CLEAR) begin
        m_bram_hist_ena   = 1'b1;
        m_bram_hist_wea   = 1'b1;
        m_bram_hist_addra = clr_adr;
      end else if (wr_vld) begin
        m_bram_hist_ena   = 1'b1;
        m_bram_hist_wea   = 1'b1;
        m_bram_hist_addra = wr_adr;
        m_bram_hist_dina  = wr_dat;
      end
    end
  end

  always_ff @(posedge i_sys_clk) begin
    if (!i_sys_resetn) begin
      for (int unsigned i = 0; i < LAT; i++) begin
        pipe_vld[i] <= 1'b0;
        pipe_adr[i] <= '0;
        hist_vld[i] <= 1'b0;
        hist_adr[i] <= '0;
        hist_dat[i] <= '0;
      end
    end else begin
      pipe_vld[0] <= pix_acc;
      pipe_adr[0] <= pix_adr;
      hist_vld[0] <= wr_vld;
      hist_adr[0] <= wr_adr;
      hist_dat[0] <= wr_dat;
      for (int unsigned i = 1; i < LAT; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_adr[i] <= pipe_adr[i-1];
        hist_vld[i] <= hist_vld[i-1];
        hist_adr[i] <= hist_adr[i-1];
        hist_dat[i] <= hist_dat[i-1];
      end
    end
  end

  always_ff @(posedge i_sys_clk) begin
    if (!i_sys_resetn) begin
      pix_cnt     <= '0;
      o_pix_count <= '0;
      err         <= '0;
    end else begin
      if (pix_acc) begin
        if (state == ST_WAIT_SOF)  pix_cnt <= 32'd1;
        else if (pix_cnt != '1)    pix_cnt <= pix_cnt + 32'd1;
      end
      if (state == ST_FLUSH && state_nxt == ST_DONE) o_pix_count <= pix_cnt;
      if (state == ST_DONE && i_bram_hist_release) begin
        err <= '0;
      end else begin
        if (wr_vld && wr_sat) err[0] <= 1'b1;
        if (pix_acc && state == ST_ACC && s_axis_pix_tuser) err[1] <= 1'b1;
        if (i_bram_hist_release && state != ST_DONE) err[2] <= 1'b1;
        if (pix_acc && state == ST_ACC && pix_cnt == '1) err[3] <= 1'b1;
      end
    end
  end

  assign m_err_histogram_info0 = WD_ERR_INFO'(err);

endmodule

// File: doc/histogram_stat.md
HISTOGRAM_STAT -- requirements
Module: histogram_stat

Interface
REQ-001 SHALL have parameter MD_SIM_ABLE, default 0: 1 shortens CLEAR to 16 bins for simulation.
REQ-002 SHALL have parameter NB_BRAM_LATCH, default 2: BRAM read latency in cycles, from enb/addrb to valid doutb (legal 1..4).
REQ-003 SHALL have parameter WD_IMG_DATA, default 8: pixel width.
REQ-004 SHALL have parameter WD_BRAM_ADR, default 8: bin address width; it SHALL equal WD_IMG_DATA.
REQ-005 SHALL have parameter WD_BRAM_DAT, default 32: bin count width.
REQ-006 SHALL have parameter WD_ERR_INFO, default 4: error vector width.
REQ-007 SHALL have port i_sys_clk, input, 1 bit: single clock. All logic is synchronous to its rising edge.
REQ-008 SHALL have port i_sys_resetn, input, 1 bit: reset, synchronous and active-low.
REQ-009 SHALL have s_axis_pix_tvalid, tready, tuser and tlast (1 bit each) and tdata (WD_IMG_DATA): pixel stream. tdata is input and the bin index; tuser is input and marks start of frame; tlast is input and marks end of frame; tready is output.
REQ-010 SHALL have m_bram_hist_ena, wea (output, 1 each), addra (output, WD_BRAM_ADR) and dina (output, WD_BRAM_DAT): BRAM write port.
REQ-011 SHALL have m_bram_hist_enb (output, 1), addrb (output, WD_BRAM_ADR) and doutb (input, WD_BRAM_DAT): BRAM read port.
REQ-012 SHALL have o_bram_hist_idle, output, 1 bit: high while the histogram is complete and the BRAM is released to histogram_sum.
REQ-013 SHALL have i_bram_hist_release, input, 1 bit: single-cycle pulse from the consumer ending ownership.
REQ-014 SHALL have o_pix_count, output, 32 bits: pixels accumulated in the last frame.
REQ-015 SHALL have m_err_histogram_info0, output, WD_ERR_INFO bits: sticky error flags.

Function
REQ-016 SHALL implement states CLEAR, WAIT_SOF, ACC, FLUSH and DONE.
REQ-017 In CLEAR, SHALL write 0 to addresses 0..2^WD_BRAM_ADR-1 (0..15 if MD_SIM_ABLE), one per cycle with ena=wea=1, then go to WAIT_SOF.
REQ-018 In WAIT_SOF, SHALL hold tready=1 and discard beats without tuser. A beat with tuser=1 SHALL be accumulated as pixel 0 and SHALL move the block to ACC.
REQ-019 In ACC, SHALL hold tready=1. Each accepted beat SHALL increment bin[tdata] by 1 via read (enb, addrb=tdata) then write after NB_BRAM_LATCH cycles.
REQ-020 Read-after-write hazard: back-to-back or in-flight equal addresses SHALL be forwarded so that every bin ends exactly equal to its accepted-pixel count. No stall SHALL occur; the block sustains 1 pixel/cycle.
REQ-021 When a bin is at 2^WD_BRAM_DAT-1, it SHALL stay there and SHALL set err bit0.
REQ-022 An accepted tuser=1 in ACC SHALL set err bit1 and SHALL be counted as a normal pixel; the frame is not restarted.
REQ-023 An accepted tlast=1 SHALL go to FLUSH with tready=0. FLUSH SHALL last until all pending writes retire (NB_BRAM_LATCH cycles), then go to DONE.
REQ-024 On entry to DONE, o_pix_count SHALL be latched. In DONE, o_bram_hist_idle=1, tready=0, and ena/enb=0.
REQ-025 i_bram_hist_release in DONE SHALL go to CLEAR and drop o_bram_hist_idle on the next cycle. In any other state it SHALL be ignored and SHALL set err bit2.
REQ-026 A tuser and tlast on the same beat SHALL be treated as a one-pixel frame.
REQ-027 A pixel count overflow past 2^32-1 SHALL saturate and SHALL set err bit3.
REQ-028 Error bits SHALL clear only on reset or on entry to CLEAR. Bits above 3 SHALL read 0.

Reset
REQ-029 While i_sys_resetn=0 at a clock edge, SHALL force the state to CLEAR with clear address 0. Outputs SHALL be: tready=0, ena=wea=enb=0, addra=addrb=dina=0, o_bram_hist_idle=0, o_pix_count=0, errors=0.
REQ-030 Reset mid-ACC or mid-FLUSH SHALL abandon pending writes. The first cycle after release SHALL begin CLEAR at address 0.

Verification
REQ-031 Reset, then 256 idle cycles: 256 writes of 0 to addresses 0..255, then tready=1.
REQ-032 A 16-pixel frame of all 0x05, tvalid continuous: bin5=16, all other bins 0, o_pix_count=16, no errors.
REQ-033 Frame of 0x01,0x02,0x01,0x01,0x02 (hazard pattern) with NB_BRAM_LATCH=2 and 3: bin1=3, bin2=2.
REQ-034 Beats before SOF discarded; a tuser mid-frame gives err bit1=1 and those pixels are counted.
REQ-035 Release pulse in DONE gives idle=0 next cycle and CLEAR restarts. A release pulse in ACC gives err bit2=1 and the state is unchanged.
REQ-036 Reset asserted mid-ACC: outputs at their reset values; after release a full CLEAR runs before tready=1.
